// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding (common with the TX side),
// parity-mode constants and the parity check helper.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_t;

  localparam logic PARITY_EVEN = 1'b0;
  localparam logic PARITY_ODD  = 1'b1;

  // red_data is the XOR-reduction of the payload, p the received parity bit.
  // The frame is good when the total count of ones matches the selected mode.
  function automatic logic parity_mismatch(input logic red_data, input logic p,
                                           input logic odd_sel);
    return (red_data ^ p) != odd_sel;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for the asynchronous serial line. Resets to 1 so an
// idle (high) line is assumed while reset is applied.
module sync_2ff (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  // Two-stage capture of the asynchronous input
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: start bit, DATA_BITS LSB-first, optional parity, one stop
// bit. The start bit is confirmed at its middle, after which the bit timer is
// restarted so every later full-period wrap lands on a bit centre.
module uart_rx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_EN    = 1,
  parameter int PARITY_ODD   = 0
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_rx,
  output logic [DATA_BITS-1:0] o_data,
  output logic                 o_valid,
  output logic                 o_parity_err,
  output logic                 o_frame_err,
  output logic                 o_busy
);
  import uart_pkg::*;

  localparam int               CNT_W    = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] MID_CNT  = CNT_W'(CLKS_PER_BIT/2 - 1);
  localparam logic [CNT_W-1:0] END_CNT  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]       LAST_BIT = 3'(DATA_BITS - 1);
  localparam logic             HAS_PAR  = (PARITY_EN != 0);
  localparam logic             ODD_SEL  = (PARITY_ODD != 0) ? uart_pkg::PARITY_ODD
                                                            : uart_pkg::PARITY_EVEN;

  logic                 w_rx_s;
  logic                 w_mid;
  logic                 w_end;

  uart_state_t          r_state;
  logic [CNT_W-1:0]     r_clk_cnt;
  logic [2:0]           r_bit_idx;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_perr;
  logic                 r_armed;
  logic [DATA_BITS-1:0] r_data;
  logic                 r_valid;
  logic                 r_parity_err;
  logic                 r_frame_err;
  logic                 r_busy;

  sync_2ff u_sync (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_d     (i_rx),
    .o_q     (w_rx_s)
  );

  assign w_mid = (r_clk_cnt == MID_CNT);
  assign w_end = (r_clk_cnt == END_CNT);

  // Receive FSM with bit timer, shift register and registered outputs
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state      <= IDLE;
      r_clk_cnt    <= '0;
      r_bit_idx    <= '0;
      r_shift      <= '0;
      r_perr       <= 1'b0;
      r_armed      <= 1'b1;
      r_data       <= '0;
      r_valid      <= 1'b0;
      r_parity_err <= 1'b0;
      r_frame_err  <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          r_clk_cnt <= '0;
          r_bit_idx <= '0;
          // After a low stop bit the line must be seen high before a new
          // falling edge counts as a start; this stops a held-low line
          // from producing a stream of zero frames.
          if (!r_armed) begin
            if (w_rx_s) r_armed <= 1'b1;
          end else if (!w_rx_s) begin
            r_state <= START;
            r_busy  <= 1'b1;
          end
        end

        START: begin
          if (w_mid) begin
            r_clk_cnt <= '0;
            if (!w_rx_s) begin
              r_state   <= DATA;
              r_bit_idx <= '0;
              r_perr    <= 1'b0;
            end else begin
              // Line went back high before mid-start: treat as a glitch
              r_state <= IDLE;
              r_busy  <= 1'b0;
            end
          end else begin
            r_clk_cnt <= r_clk_cnt + 1'b1;
          end
        end

        DATA: begin
          if (w_end) begin
            r_clk_cnt <= '0;
            r_shift   <= {w_rx_s, r_shift[DATA_BITS-1:1]};
            if (r_bit_idx == LAST_BIT) begin
              r_state <= HAS_PAR ? PARITY : STOP;
            end else begin
              r_bit_idx <= r_bit_idx + 1'b1;
            end
          end else begin
            r_clk_cnt <= r_clk_cnt + 1'b1;
          end
        end

        PARITY: begin
          if (w_end) begin
            r_clk_cnt <= '0;
            r_perr    <= parity_mismatch(^r_shift, w_rx_s, ODD_SEL);
            r_state   <= STOP;
          end else begin
            r_clk_cnt <= r_clk_cnt + 1'b1;
          end
        end

        STOP: begin
          if (w_end) begin
            // Frame is reported even on errors; the consumer qualifies it
            r_clk_cnt    <= '0;
            r_state      <= IDLE;
            r_busy       <= 1'b0;
            r_data       <= r_shift;
            r_valid      <= 1'b1;
            r_parity_err <= HAS_PAR & r_perr;
            r_frame_err  <= ~w_rx_s;
            r_armed      <= w_rx_s;
          end else begin
            r_clk_cnt <= r_clk_cnt + 1'b1;
          end
        end

        default: begin
          r_state   <= IDLE;
          r_busy    <= 1'b0;
          r_clk_cnt <= '0;
        end
      endcase
    end
  end

  assign o_data       = r_data;
  assign o_valid      = r_valid;
  assign o_parity_err = r_parity_err;
  assign o_frame_err  = r_frame_err;
  assign o_busy       = r_busy;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: one parity-enabled receiver and one parity-less
// receiver, each driven by a bit-level serial sender. Every frame sent
// queues its expected payload, flags and send time; a single compare
// process checks each valid pulse against that queue and the held outputs
// on every other cycle.
module tb_uart_rx;

  localparam int CPB = 16;
  // Nominal valid latency from the falling start edge
  localparam int LAT_P  = 2 + CPB/2 + 10*CPB;
  localparam int LAT_NP = 2 + CPB/2 + 9*CPB;

  typedef struct {
    logic [7:0] d;
    logic       pe;
    logic       fe;
    int         t0;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx0 = 1'b1;
  logic       rx1 = 1'b1;
  logic [7:0] d0, d1;
  logic       v0, v1, pe0, pe1, fe0, fe1, b0, b1;

  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;
  int         vcount [2];
  int         lastlat [2];
  logic [7:0] hd [2];
  logic       hpe [2];
  logic       hfe [2];
  exp_t       q0 [$];
  exp_t       q1 [$];

  uart_rx #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0)) u_dut (
    .i_clk(clk), .i_reset(rst_n), .i_rx(rx0), .o_data(d0), .o_valid(v0),
    .o_parity_err(pe0), .o_frame_err(fe0), .o_busy(b0)
  );

  uart_rx #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0)) u_dut_np (
    .i_clk(clk), .i_reset(rst_n), .i_rx(rx1), .o_data(d1), .o_valid(v1),
    .o_parity_err(pe1), .o_frame_err(fe1), .o_busy(b1)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // One cycle of comparison for receiver d
  task automatic step(input int d, input logic v, input logic [7:0] data,
                      input logic pe, input logic fe);
    exp_t e;
    int   lat;
    int   lnom;
    lnom = (d == 0) ? LAT_P : LAT_NP;
    if (v) begin
      vcount[d]++;
      if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid dut%0d: got o_valid=1 expected 0 (cycle %0d)", d, cyc);
      end else begin
        if (d == 0) e = q0.pop_front();
        else        e = q1.pop_front();
        lat = cyc - e.t0;
        lastlat[d] = lat;
        checks++;
        if (lat < lnom - 1 || lat > lnom + 2) begin
          errors++;
          $display("FAIL latency dut%0d: got %0d expected %0d..%0d", d, lat, lnom - 1, lnom + 2);
        end
        hd[d]  = e.d;
        hpe[d] = e.pe;
        hfe[d] = e.fe;
      end
    end
    chk($sformatf("data_dut%0d", d), int'(data), int'(hd[d]));
    chk($sformatf("parity_err_dut%0d", d), int'(pe), int'(hpe[d]));
    chk($sformatf("frame_err_dut%0d", d), int'(fe), int'(hfe[d]));
  endtask

  // Compare process, sampled 1 time unit after the active edge
  always @(posedge clk) begin
    #1;
    if (rst_n) begin
      step(0, v0, d0, pe0, fe0);
      step(1, v1, d1, pe1, fe1);
    end
  end

  task automatic drv(input int d, input logic b);
    if (d == 0) rx0 = b;
    else        rx1 = b;
  endtask

  task automatic idle(input int d, input int n);
    drv(d, 1'b1);
    repeat (n) @(negedge clk);
  endtask

  // Send one frame on line d; dut0 frames carry the parity bit p
  task automatic send(input int d, input logic [7:0] data, input logic p, input logic s);
    exp_t e;
    e.d  = data;
    e.pe = (d == 0) ? (p != (^data)) : 1'b0;
    e.fe = ~s;
    e.t0 = cyc;
    if (d == 0) q0.push_back(e);
    else        q1.push_back(e);
    drv(d, 1'b0);
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      drv(d, data[i]);
      repeat (CPB) @(negedge clk);
    end
    if (d == 0) begin
      drv(d, p);
      repeat (CPB) @(negedge clk);
    end
    drv(d, s);
    repeat (CPB) @(negedge clk);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q0.size() != 0 || q1.size() != 0) && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("drain_pending_frames", q0.size() + q1.size(), 0);
    q0.delete();
    q1.delete();
  endtask

  initial begin
    int   vc;
    int   vc1;
    bit   bseen;
    exp_t e;
    logic [7:0] rd;
    logic rp, rs;
    int   gap;

    for (int i = 0; i < 2; i++) begin
      vcount[i] = 0; lastlat[i] = 0; hd[i] = '0; hpe[i] = 1'b0; hfe[i] = 1'b0;
    end

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_valid", int'(v0), 0);
    chk("rst_data", int'(d0), 0);
    chk("rst_perr", int'(pe0), 0);
    chk("rst_ferr", int'(fe0), 0);
    chk("rst_busy", int'(b0), 0);
    chk("rst_busy_np", int'(b1), 0);
    rst_n = 1'b1;
    idle(0, 20);

    // Clean even-parity frame
    vc = vcount[0];
    send(0, 8'hA5, 1'b0, 1'b1);
    idle(0, 8);
    drain();
    chk("s1_nvalid", vcount[0] - vc, 1);
    chk("s1_data", int'(d0), 'hA5);
    chk("s1_perr", int'(pe0), 0);
    chk("s1_ferr", int'(fe0), 0);

    // Wrong parity bit
    vc = vcount[0];
    send(0, 8'h3C, 1'b1, 1'b1);
    idle(0, 8);
    drain();
    chk("s2_nvalid", vcount[0] - vc, 1);
    chk("s2_data", int'(d0), 'h3C);
    chk("s2_perr", int'(pe0), 1);
    chk("s2_ferr", int'(fe0), 0);

    // Low stop bit then line held low for 40 bit times
    vc = vcount[0];
    send(0, 8'h55, 1'b0, 1'b0);
    repeat (40*CPB) @(negedge clk);
    idle(0, 40);
    drain();
    chk("s3_nvalid", vcount[0] - vc, 1);
    chk("s3_data", int'(d0), 'h55);
    chk("s3_ferr", int'(fe0), 1);
    vc = vcount[0];
    send(0, 8'h99, 1'b0, 1'b1);
    idle(0, 8);
    drain();
    chk("s3_next_nvalid", vcount[0] - vc, 1);
    chk("s3_next_data", int'(d0), 'h99);
    chk("s3_next_ferr", int'(fe0), 0);

    // Idle line pulled low and held: one all-zero framing-error frame
    vc = vcount[0];
    e.d = 8'h00; e.pe = 1'b0; e.fe = 1'b1; e.t0 = cyc;
    q0.push_back(e);
    drv(0, 1'b0);
    repeat (20*CPB) @(negedge clk);
    idle(0, 40);
    drain();
    chk("hold_low_nvalid", vcount[0] - vc, 1);
    chk("hold_low_data", int'(d0), 0);
    chk("hold_low_ferr", int'(fe0), 1);

    // Short glitch on idle line
    vc = vcount[0];
    bseen = 1'b0;
    drv(0, 1'b0);
    repeat (5) begin @(negedge clk); if (b0) bseen = 1'b1; end
    drv(0, 1'b1);
    repeat (30) begin @(negedge clk); if (b0) bseen = 1'b1; end
    chk("s4_busy_pulsed", int'(bseen), 1);
    chk("s4_nvalid", vcount[0] - vc, 0);
    chk("s4_busy_end", int'(b0), 0);

    // Back-to-back frames, no idle gap
    vc = vcount[0];
    send(0, 8'h00, 1'b0, 1'b1);
    send(0, 8'hFF, 1'b0, 1'b1);
    send(0, 8'h81, 1'b0, 1'b1);
    idle(0, 8);
    drain();
    chk("s5_nvalid", vcount[0] - vc, 3);
    chk("s5_data", int'(d0), 'h81);
    chk("s5_perr", int'(pe0), 0);
    chk("s5_ferr", int'(fe0), 0);

    // Reset during data bit 4
    vc = vcount[0];
    rd = 8'h7E;
    drv(0, 1'b0);
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      drv(0, rd[i]);
      repeat (CPB) @(negedge clk);
    end
    drv(0, rd[4]);
    repeat (CPB/2) @(negedge clk);
    rst_n = 1'b0;
    q0.delete();
    for (int i = 0; i < 2; i++) begin hd[i] = '0; hpe[i] = 1'b0; hfe[i] = 1'b0; end
    #1;
    chk("s6_rst_valid", int'(v0), 0);
    chk("s6_rst_data", int'(d0), 0);
    chk("s6_rst_perr", int'(pe0), 0);
    chk("s6_rst_ferr", int'(fe0), 0);
    chk("s6_rst_busy", int'(b0), 0);
    drv(0, 1'b1);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    idle(0, 20);
    chk("s6_no_valid", vcount[0] - vc, 0);
    send(0, 8'h42, 1'b0, 1'b1);
    idle(0, 8);
    drain();
    chk("s6_nvalid", vcount[0] - vc, 1);
    chk("s6_data", int'(d0), 'h42);
    chk("s6_perr", int'(pe0), 0);

    // Parity-less receiver: one bit period shorter
    vc1 = vcount[1];
    send(1, 8'hC3, 1'b0, 1'b1);
    idle(1, 8);
    drain();
    chk("s7_nvalid", vcount[1] - vc1, 1);
    chk("s7_data", int'(d1), 'hC3);
    chk("s7_perr", int'(pe1), 0);
    chk("s7_lat_delta", lastlat[0] - lastlat[1], CPB);

    // Randomized frames on both receivers
    for (int n = 0; n < 30; n++) begin
      rd  = 8'($urandom_range(0, 255));
      rp  = ($urandom_range(0, 3) == 0) ? ~(^rd) : (^rd);
      rs  = ($urandom_range(0, 5) != 0);
      gap = rs ? int'($urandom_range(0, 12)) : int'($urandom_range(4, 12));
      send(0, rd, rp, rs);
      idle(0, gap);
    end
    for (int n = 0; n < 10; n++) begin
      rd  = 8'($urandom_range(0, 255));
      rs  = ($urandom_range(0, 5) != 0);
      gap = rs ? int'($urandom_range(0, 12)) : int'($urandom_range(4, 12));
      send(1, rd, 1'b0, rs);
      idle(1, gap);
    end
    idle(0, 20);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
